// File: rtl/uart_packet_rx.sv
// uart_packet_rx: 8N1 UART receiver with 16x oversampling and a packet deframer.
// It recovers packets of the form SYNC, LEN, payload, CSUM.
// Payload bytes leave on a valid/ready stream; per-packet status is signalled with single-cycle pulses.
module uart_packet_rx #(
    parameter int         ClockFrequency = 50_000_000,
    parameter int         BaudRate       = 115200,
    parameter int         Oversample     = 16,
    parameter logic [7:0] SyncByte       = 8'hA5,
    parameter int         TimeoutBits    = 40
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_rx,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    output logic       o_pkt_ok,
    output logic       o_pkt_err,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int Div          = ClockFrequency / (BaudRate * Oversample);
    localparam int TickW        = (Div > 1) ? $clog2(Div) : 1;
    localparam int SampW        = $clog2(Oversample);
    localparam int TimeoutTicks = TimeoutBits * Oversample;
    localparam int ToW          = $clog2(TimeoutTicks + 1);

    localparam logic [TickW-1:0] TickLast   = TickW'(Div - 1);
    localparam logic [SampW-1:0] SampleLast = SampW'(Oversample - 1);
    localparam logic [ToW-1:0]   ToLast     = ToW'(TimeoutTicks - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} RxState;
    typedef enum logic [1:0] {P_HUNT, P_LEN, P_PAY, P_CSUM} PktState;

    RxState           rState;
    PktState          pState;
    logic             rxMeta, rxS, rxPrev;
    logic [TickW-1:0] tickCnt;
    logic [SampW-1:0] sampleCnt;
    logic [2:0]       bitCnt;
    logic             startTail;
    logic             sampA, sampB;
    logic [7:0]       shiftReg;
    logic [7:0]       cnt;
    logic [7:0]       csum;
    logic             errSticky;
    logic [ToW-1:0]   toCnt;

    logic tick, fallEdge, majority, stopSample, byteStb, frameErrNow;

    assign tick        = (tickCnt == TickLast);
    assign fallEdge    = rxPrev & ~rxS;
    assign majority    = (sampA & sampB) | (sampA & rxS) | (sampB & rxS);
    assign stopSample  = (rState == R_STOP) && tick && (sampleCnt == SampW'(7));
    assign byteStb     = stopSample && majority;
    assign frameErrNow = stopSample && !majority;
    assign o_busy      = (pState != P_HUNT);

    // Synchronise the pin, generate sample ticks and run the bit-level receiver.
    // The stop bit is voted from samples 5, 6 and 7, so the receiver can return to idle at
    // sample 7 and still catch a start edge that follows straight after a short stop bit.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rxMeta      <= 1'b1;
            rxS         <= 1'b1;
            rxPrev      <= 1'b1;
            tickCnt     <= '0;
            sampleCnt   <= '0;
            bitCnt      <= '0;
            startTail   <= 1'b0;
            sampA       <= 1'b0;
            sampB       <= 1'b0;
            shiftReg    <= '0;
            o_frame_err <= 1'b0;
            rState      <= R_IDLE;
        end else begin
            rxMeta      <= i_rx;
            rxS         <= rxMeta;
            rxPrev      <= rxS;
            o_frame_err <= frameErrNow;

            if ((rState == R_IDLE && fallEdge) || tick) begin
                tickCnt <= '0;
            end else begin
                tickCnt <= tickCnt + 1'b1;
            end

            if (rState != R_IDLE && tick) begin
                sampleCnt <= (sampleCnt == SampleLast) ? '0 : sampleCnt + 1'b1;
            end

            case (rState)
                R_IDLE: begin
                    if (fallEdge) begin
                        sampleCnt <= '0;
                        rState    <= R_START;
                    end
                end
                R_START: begin
                    if (tick && sampleCnt == SampW'(7)) begin
                        if (rxS) begin
                            rState <= R_IDLE;
                        end else begin
                            startTail <= 1'b1;
                            bitCnt    <= '0;
                            rState    <= R_DATA;
                        end
                    end
                end
                R_DATA: begin
                    if (tick) begin
                        if (!startTail && sampleCnt == SampW'(6)) sampA <= rxS;
                        if (!startTail && sampleCnt == SampW'(7)) sampB <= rxS;
                        if (!startTail && sampleCnt == SampW'(8)) shiftReg <= {majority, shiftReg[7:1]};
                        if (sampleCnt == SampleLast) begin
                            if (startTail) begin
                                startTail <= 1'b0;
                            end else if (bitCnt == 3'd7) begin
                                rState <= R_STOP;
                            end else begin
                                bitCnt <= bitCnt + 1'b1;
                            end
                        end
                    end
                end
                R_STOP: begin
                    if (tick) begin
                        if (sampleCnt == SampW'(5)) sampA <= rxS;
                        if (sampleCnt == SampW'(6)) sampB <= rxS;
                        if (sampleCnt == SampW'(7)) rState <= R_IDLE;
                    end
                end
                default: rState <= R_IDLE;
            endcase
        end
    end

    // Packet deframer, output register, checksum, inter-byte timeout and error reporting.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pState    <= P_HUNT;
            cnt       <= '0;
            csum      <= '0;
            errSticky <= 1'b0;
            toCnt     <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_pkt_ok  <= 1'b0;
            o_pkt_err <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_pkt_ok  <= 1'b0;
            o_pkt_err <= 1'b0;
            o_overrun <= 1'b0;

            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end

            if (pState == P_HUNT || byteStb) begin
                toCnt <= '0;
            end else if (tick) begin
                toCnt <= toCnt + 1'b1;
            end

            if (pState != P_HUNT && frameErrNow) begin
                pState    <= P_HUNT;
                o_pkt_err <= 1'b1;
            end else if (pState != P_HUNT && tick && toCnt == ToLast) begin
                pState    <= P_HUNT;
                o_pkt_err <= 1'b1;
            end else if (byteStb) begin
                case (pState)
                    P_HUNT: begin
                        if (shiftReg == SyncByte) begin
                            errSticky <= 1'b0;
                            pState    <= P_LEN;
                        end
                    end
                    P_LEN: begin
                        cnt    <= shiftReg;
                        csum   <= shiftReg;
                        pState <= (shiftReg == 8'd0) ? P_CSUM : P_PAY;
                    end
                    P_PAY: begin
                        csum <= csum ^ shiftReg;
                        cnt  <= cnt - 1'b1;
                        if (!o_valid || i_ready) begin
                            o_data  <= shiftReg;
                            o_valid <= 1'b1;
                            o_last  <= (cnt == 8'd1);
                        end else begin
                            o_overrun <= 1'b1;
                            errSticky <= 1'b1;
                        end
                        if (cnt == 8'd1) pState <= P_CSUM;
                    end
                    P_CSUM: begin
                        if (shiftReg == csum && !errSticky) begin
                            o_pkt_ok <= 1'b1;
                        end else begin
                            o_pkt_err <= 1'b1;
                        end
                        pState <= P_HUNT;
                    end
                    default: pState <= P_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// tb_uart_packet_rx: drives serial packets into uart_packet_rx and scoreboards the payload stream and status pulses.
module tb_uart_packet_rx;

    localparam int ClockFreq = 7_372_800;
    localparam int BitCycles = 64;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_last, o_pkt_ok, o_pkt_err, o_frame_err, o_overrun, o_busy;

    int checks = 0;
    int passes = 0;
    int okCnt = 0, errCnt = 0, feCnt = 0, ovCnt = 0;
    int ok0, err0, fe0, ov0;
    logic [8:0] expQ[$];

    uart_packet_rx #(.ClockFrequency(ClockFreq)) dut (
        .CLK(CLK), .RST(RST), .i_rx(i_rx), .i_ready(i_ready),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last),
        .o_pkt_ok(o_pkt_ok), .o_pkt_err(o_pkt_err), .o_frame_err(o_frame_err),
        .o_overrun(o_overrun), .o_busy(o_busy)
    );

    always #5 CLK = ~CLK;

    // Count status pulses and pop the scoreboard on every accepted payload byte.
    always @(negedge CLK) begin
        logic [8:0] e;
        if (o_pkt_ok) okCnt++;
        if (o_pkt_err) errCnt++;
        if (o_frame_err) feCnt++;
        if (o_overrun) ovCnt++;
        if (o_valid && i_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_byte: got %h last=%0d, none expected", o_data, o_last);
            end else begin
                e = expQ.pop_front();
                if ({o_last, o_data} !== e)
                    $display("[TB] FAIL payload: got last=%0d data=%h expected last=%0d data=%h", o_last, o_data, e[8], e[7:0]);
                else
                    passes++;
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        i_rx = 1'b0;
        waitCycles(BitCycles);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            waitCycles(BitCycles);
        end
        i_rx = stopBit;
        waitCycles(BitCycles);
        i_rx = 1'b1;
    endtask

    task automatic snapshot();
        ok0 = okCnt; err0 = errCnt; fe0 = feCnt; ov0 = ovCnt;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        waitCycles(5);
        checks++;
        if ({o_data, o_valid, o_last, o_pkt_ok, o_pkt_err, o_frame_err, o_overrun, o_busy} !== 15'd0)
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {o_data, o_valid, o_last, o_pkt_ok, o_pkt_err, o_frame_err, o_overrun, o_busy});
        else passes++;
        RST = 1'b1;
        waitCycles(2 * BitCycles);
    endtask

    task automatic test_good_packet();
        logic [7:0] pkt[6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        snapshot();
        expQ.push_back({1'b0, 8'h11});
        expQ.push_back({1'b0, 8'h22});
        expQ.push_back({1'b1, 8'h33});
        foreach (pkt[i]) applyStimulus(pkt[i], 1'b1);
        waitCycles(BitCycles);
        checks++; if (okCnt - ok0 !== 1) $display("[TB] FAIL good_ok: got %0d expected 1", okCnt - ok0); else passes++;
        checks++; if (errCnt - err0 !== 0) $display("[TB] FAIL good_err: got %0d expected 0", errCnt - err0); else passes++;
        checks++; if (feCnt + ovCnt - fe0 - ov0 !== 0) $display("[TB] FAIL good_other: got %0d expected 0", feCnt + ovCnt - fe0 - ov0); else passes++;
        checks++; if (expQ.size() !== 0) $display("[TB] FAIL good_drain: got %0d left expected 0", expQ.size()); else passes++;
        checks++; if (o_busy !== 1'b0) $display("[TB] FAIL good_busy: got %0d expected 0", o_busy); else passes++;
    endtask

    task automatic test_bad_csum();
        logic [7:0] pkt[5] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        snapshot();
        expQ.push_back({1'b0, 8'h10});
        expQ.push_back({1'b1, 8'h20});
        foreach (pkt[i]) applyStimulus(pkt[i], 1'b1);
        waitCycles(BitCycles);
        checks++; if (errCnt - err0 !== 1) $display("[TB] FAIL csum_err: got %0d expected 1", errCnt - err0); else passes++;
        checks++; if (okCnt - ok0 !== 0) $display("[TB] FAIL csum_ok: got %0d expected 0", okCnt - ok0); else passes++;
        checks++; if (expQ.size() !== 0) $display("[TB] FAIL csum_drain: got %0d left expected 0", expQ.size()); else passes++;
    endtask

    task automatic test_overrun();
        logic [7:0] pkt[5] = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13};
        snapshot();
        i_ready = 1'b0;
        foreach (pkt[i]) applyStimulus(pkt[i], 1'b1);
        waitCycles(BitCycles);
        checks++; if (o_valid !== 1'b1 || o_data !== 8'hAA) $display("[TB] FAIL ovr_hold: got valid=%0d data=%h expected valid=1 data=aa", o_valid, o_data); else passes++;
        checks++; if (ovCnt - ov0 !== 1) $display("[TB] FAIL ovr_pulse: got %0d expected 1", ovCnt - ov0); else passes++;
        checks++; if (errCnt - err0 !== 1 || okCnt - ok0 !== 0) $display("[TB] FAIL ovr_status: got err=%0d ok=%0d expected err=1 ok=0", errCnt - err0, okCnt - ok0); else passes++;
        expQ.push_back({1'b0, 8'hAA});
        i_ready = 1'b1;
        waitCycles(3);
        checks++; if (o_valid !== 1'b0 || expQ.size() !== 0) $display("[TB] FAIL ovr_release: got valid=%0d left=%0d expected 0/0", o_valid, expQ.size()); else passes++;
    endtask

    task automatic test_glitch_hunt();
        logic [7:0] pkt[3] = '{8'hA5, 8'h00, 8'h00};
        snapshot();
        i_rx = 1'b0;
        waitCycles(4);
        i_rx = 1'b1;
        waitCycles(2 * BitCycles);
        applyStimulus(8'h5A, 1'b1);
        waitCycles(BitCycles);
        checks++; if (o_busy !== 1'b0 || feCnt - fe0 !== 0) $display("[TB] FAIL glitch_idle: got busy=%0d fe=%0d expected 0/0", o_busy, feCnt - fe0); else passes++;
        foreach (pkt[i]) applyStimulus(pkt[i], 1'b1);
        waitCycles(BitCycles);
        checks++; if (okCnt - ok0 !== 1 || errCnt - err0 !== 0) $display("[TB] FAIL glitch_pkt: got ok=%0d err=%0d expected 1/0", okCnt - ok0, errCnt - err0); else passes++;
    endtask

    task automatic test_timeout();
        logic [7:0] pkt[3] = '{8'hA5, 8'h04, 8'h01};
        snapshot();
        expQ.push_back({1'b0, 8'h01});
        foreach (pkt[i]) applyStimulus(pkt[i], 1'b1);
        checks++; if (o_busy !== 1'b1) $display("[TB] FAIL to_busy: got %0d expected 1", o_busy); else passes++;
        waitCycles(30 * BitCycles);
        checks++; if (errCnt - err0 !== 0) $display("[TB] FAIL to_early: got %0d expected 0", errCnt - err0); else passes++;
        waitCycles(11 * BitCycles);
        checks++; if (errCnt - err0 !== 1) $display("[TB] FAIL to_err: got %0d expected 1", errCnt - err0); else passes++;
        checks++; if (o_busy !== 1'b0 || expQ.size() !== 0) $display("[TB] FAIL to_idle: got busy=%0d left=%0d expected 0/0", o_busy, expQ.size()); else passes++;
    endtask

    task automatic test_frame_and_reset();
        logic [7:0] good[4] = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        snapshot();
        expQ.push_back({1'b0, 8'h01});
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b0);
        waitCycles(BitCycles);
        checks++; if (feCnt - fe0 !== 1 || errCnt - err0 !== 1) $display("[TB] FAIL frame_pulses: got fe=%0d err=%0d expected 1/1", feCnt - fe0, errCnt - err0); else passes++;
        checks++; if (o_busy !== 1'b0 || okCnt - ok0 !== 0) $display("[TB] FAIL frame_abort: got busy=%0d ok=%0d expected 0/0", o_busy, okCnt - ok0); else passes++;
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h05, 1'b1);
        i_rx = 1'b0;
        waitCycles(BitCycles + BitCycles / 2);
        snapshot();
        RST = 1'b0;
        waitCycles(3);
        i_rx = 1'b1;
        checks++;
        if ({o_data, o_valid, o_last, o_pkt_ok, o_pkt_err, o_frame_err, o_overrun, o_busy} !== 15'd0)
            $display("[TB] FAIL midreset_outputs: got %h expected 0",
                     {o_data, o_valid, o_last, o_pkt_ok, o_pkt_err, o_frame_err, o_overrun, o_busy});
        else passes++;
        RST = 1'b1;
        waitCycles(12 * BitCycles);
        checks++; if (okCnt + errCnt + feCnt + ovCnt - ok0 - err0 - fe0 - ov0 !== 0 || o_busy !== 1'b0) $display("[TB] FAIL midreset_quiet: got pulses=%0d busy=%0d expected 0/0", okCnt + errCnt + feCnt + ovCnt - ok0 - err0 - fe0 - ov0, o_busy); else passes++;
        expQ.push_back({1'b1, 8'h7E});
        foreach (good[i]) applyStimulus(good[i], 1'b1);
        waitCycles(BitCycles);
        checks++; if (okCnt - ok0 !== 1 || errCnt - err0 !== 0) $display("[TB] FAIL after_reset_pkt: got ok=%0d err=%0d expected 1/0", okCnt - ok0, errCnt - err0); else passes++;
        checks++; if (expQ.size() !== 0) $display("[TB] FAIL after_reset_drain: got %0d left expected 0", expQ.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_csum();
        test_overrun();
        test_glitch_hunt();
        test_timeout();
        test_frame_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
